// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and constants for the RAM arbiter slice.
//   size_t  : store/load access size as carried on b_size (2'b11 is treated as a word)
//   state_t : arbiter FSM states
//   port_t  : requester identity, used for the round-robin history
//   WORD_W  : RAM word width seen by the requesters
//   LANES   : byte lanes per word
package ram_arb_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // Byte and half stores need the old word, so they go through RMW.
    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/ram_arb_merge.sv
// ram_arb_merge
//   Combinational lane merge for partial stores. The store data is
//   right-aligned, so a byte replaces lane 0 and a half replaces lanes 0-1;
//   any other size replaces the whole word.
// Ports
//   old_word  in   WORD_W  word currently held in the RAM
//   wdata     in   WORD_W  right-aligned store data
//   size      in   2       access size (size_t encoding)
//   new_word  out  WORD_W  word to write back
module ram_arb_merge
    import ram_arb_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        size,
    output logic [WORD_W-1:0] new_word
);

    always_comb begin
        new_word = old_word;
        case (size)
            SZ_BYTE: new_word[LANE_W-1:0]   = wdata[LANE_W-1:0];
            SZ_HALF: new_word[2*LANE_W-1:0] = wdata[2*LANE_W-1:0];
            default: new_word               = wdata;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one byte-addressed 32-bit-word RAM (combinational read, sync
//   word write) between an instruction-fetch port A (read-only) and a
//   load/store port B. At most one grant per cycle, only in IDLE. Read data
//   is registered and flagged with a one-cycle rvalid. Word stores write in
//   the grant cycle; byte/half stores read the old word in the grant cycle
//   and write the merged word in a single RMW cycle.
//
//   Optional build macro RAM_ARB_ROUND_ROBIN_EN: on a tie, the requester not
//   granted last wins (A wins the first tie after reset). Without it B has
//   fixed priority over A and no grant history is kept.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   a_req/a_addr -> a_gnt           fetch request/accept
//   a_rvalid, a_rdata               fetched word, 1 cycle after a_gnt
//   b_req/b_we/b_size/b_addr/b_wdata -> b_gnt   load/store request/accept
//   b_rvalid, b_rdata               loaded word, 1 cycle after a load b_gnt
//   ram_read_addr, ram_dout         RAM read port
//   ram_write_addr, ram_din, ram_write_en   RAM write port
//
// States
//   IDLE | accepting requests; reads and word stores complete here
//   RMW  | writing back a merged byte/half store; no grants issued
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [WORD_W-1:0]     a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [1:0]            b_size,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WORD_W-1:0]     b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [WORD_W-1:0]     b_rdata,

    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [WORD_W-1:0]     ram_din,
    output logic                  ram_write_en,
    input  logic [WORD_W-1:0]     ram_dout
);

    state_t                state_q, state_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [WORD_W-1:0]     a_rdata_q, a_rdata_d;
    logic [WORD_W-1:0]     b_rdata_q, b_rdata_d;
    logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
    logic [WORD_W-1:0]     rmw_wdata_q, rmw_wdata_d;
    logic [1:0]            rmw_size_q, rmw_size_d;
    logic [WORD_W-1:0]     old_word_q, old_word_d;
    logic [WORD_W-1:0]     merged_word;
    logic                  win_a, win_b;

    ram_arb_merge #(
        .LANE_W (DATA_WIDTH)
    ) u_merge (
        .old_word (old_word_q),
        .wdata    (rmw_wdata_q),
        .size     (rmw_size_q),
        .new_word (merged_word)
    );

`ifdef RAM_ARB_ROUND_ROBIN_EN
    port_t last_gnt_q, last_gnt_d;

    always_comb begin
        win_a = a_req & (~b_req | (last_gnt_q == PORT_B));
        win_b = b_req & (~a_req | (last_gnt_q == PORT_A));
    end
`else
    always_comb begin
        win_a = a_req & ~b_req;
        win_b = b_req;
    end
`endif

    always_comb begin
        state_d        = state_q;
        a_rvalid_d     = 1'b0;
        b_rvalid_d     = 1'b0;
        a_rdata_d      = a_rdata_q;
        b_rdata_d      = b_rdata_q;
        rmw_addr_d     = rmw_addr_q;
        rmw_wdata_d    = rmw_wdata_q;
        rmw_size_d     = rmw_size_q;
        old_word_d     = old_word_q;
        a_gnt          = 1'b0;
        b_gnt          = 1'b0;
        ram_read_addr  = a_addr;
        ram_write_addr = b_addr;
        ram_din        = b_wdata;
        ram_write_en   = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_gnt_d     = last_gnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (win_a) begin
                    a_gnt         = 1'b1;
                    ram_read_addr = a_addr;
                    a_rdata_d     = ram_dout;
                    a_rvalid_d    = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_gnt_d    = PORT_A;
`endif
                end else if (win_b) begin
                    b_gnt = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_gnt_d = PORT_B;
`endif
                    if (!b_we) begin
                        ram_read_addr = b_addr;
                        b_rdata_d     = ram_dout;
                        b_rvalid_d    = 1'b1;
                    end else if (is_sub_word(b_size)) begin
                        ram_read_addr = b_addr;
                        old_word_d    = ram_dout;
                        rmw_addr_d    = b_addr;
                        rmw_wdata_d   = b_wdata;
                        rmw_size_d    = b_size;
                        state_d       = RMW;
                    end else begin
                        ram_write_addr = b_addr;
                        ram_din        = b_wdata;
                        ram_write_en   = 1'b1;
                    end
                end
            end
            RMW: begin
                ram_write_addr = rmw_addr_q;
                ram_din        = merged_word;
                ram_write_en   = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The RAM write is synchronous, so a reset asserted mid-RMW must
        // block the write combinationally; grants are held off likewise.
        if (!rst_n) begin
            a_gnt        = 1'b0;
            b_gnt        = 1'b0;
            ram_write_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_size_q  <= SZ_WORD;
            old_word_q  <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_gnt_q  <= PORT_B;
`endif
        end else begin
            state_q     <= state_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_size_q  <= rmw_size_d;
            old_word_q  <= old_word_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_gnt_q  <= last_gnt_d;
`endif
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req;
    logic [11:0] a_addr;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req, b_we;
    logic [1:0]  b_size;
    logic [11:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic [11:0] ram_read_addr, ram_write_addr;
    logic [31:0] ram_din, ram_dout;
    logic        ram_write_en;

    logic [31:0] mem [1024];
    int          wr_cnt = 0;
    int          tests  = 0;
    int          failed = 0;
    int          wr_base;
    logic        exp_a [4];
    logic        exp_b [4];

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_req          (a_req),
        .a_addr         (a_addr),
        .a_gnt          (a_gnt),
        .a_rvalid       (a_rvalid),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_we           (b_we),
        .b_size         (b_size),
        .b_addr         (b_addr),
        .b_wdata        (b_wdata),
        .b_gnt          (b_gnt),
        .b_rvalid       (b_rvalid),
        .b_rdata        (b_rdata),
        .ram_read_addr  (ram_read_addr),
        .ram_write_addr (ram_write_addr),
        .ram_din        (ram_din),
        .ram_write_en   (ram_write_en),
        .ram_dout       (ram_dout)
    );

    // RAM model: combinational read, synchronous word write.
    assign ram_dout = mem[ram_read_addr[11:2]];

    always @(posedge clk) begin
        if (ram_write_en) begin
            mem[ram_write_addr[11:2]] <= ram_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [1:0] sz,
                           input logic [11:0] ad, input logic [31:0] wd);
        b_req   = req;
        b_we    = we;
        b_size  = sz;
        b_addr  = ad;
        b_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[12'h010 >> 2] = 32'hDEADBEEF;
        mem[12'h030 >> 2] = 32'hAABBCCDD;

`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        rst_n  = 1'b0;
        a_req  = 1'b0;
        a_addr = '0;
        drive_b(1'b1, 1'b1, 2'b10, 12'h050, 32'hFFFFFFFF);
        repeat (2) @(posedge clk);

        // Reset state, with a word store pending that must not be granted
        @(negedge clk); #1;
        chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'h0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        chk("rst_write_en", 32'(ram_write_en), 32'h0);
        chk("rst_b_gnt", 32'(b_gnt), 32'h0);
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);

        // 1. A fetch
        @(negedge clk);
        rst_n  = 1'b1;
        a_req  = 1'b1;
        a_addr = 12'h010;
        #1;
        chk("t1_a_gnt", 32'(a_gnt), 32'h1);
        chk("t1_read_addr", 32'(ram_read_addr), 32'h010);
        chk("t1_write_en", 32'(ram_write_en), 32'h0);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        chk("t1_a_rvalid", 32'(a_rvalid), 32'h1);
        chk("t1_a_rdata", a_rdata, 32'hDEADBEEF);
        chk("t1_a_gnt_off", 32'(a_gnt), 32'h0);
        @(negedge clk); #1;
        chk("t1_a_rvalid_pulse", 32'(a_rvalid), 32'h0);

        // 2. Word store then load
        wr_base = wr_cnt;
        drive_b(1'b1, 1'b1, 2'b10, 12'h020, 32'h11223344);
        #1;
        chk("t2_st_gnt", 32'(b_gnt), 32'h1);
        chk("t2_st_we", 32'(ram_write_en), 32'h1);
        chk("t2_st_waddr", 32'(ram_write_addr), 32'h020);
        chk("t2_st_din", ram_din, 32'h11223344);
        @(negedge clk);
        drive_b(1'b1, 1'b0, 2'b10, 12'h020, 32'h0);
        #1;
        chk("t2_ld_gnt", 32'(b_gnt), 32'h1);
        chk("t2_ld_we", 32'(ram_write_en), 32'h0);
        chk("t2_st_no_rvalid", 32'(b_rvalid), 32'h0);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        #1;
        chk("t2_ld_rvalid", 32'(b_rvalid), 32'h1);
        chk("t2_ld_rdata", b_rdata, 32'h11223344);
        chk("t2_wr_count", 32'(wr_cnt - wr_base), 32'h1);

        // 3. Byte store via RMW, load readback; then half store
        @(negedge clk);
        drive_b(1'b1, 1'b1, 2'b00, 12'h030, 32'hFFFFFF55);
        #1;
        chk("t3b_gnt", 32'(b_gnt), 32'h1);
        chk("t3b_gnt_we", 32'(ram_write_en), 32'h0);
        chk("t3b_raddr", 32'(ram_read_addr), 32'h030);
        @(negedge clk);
        drive_b(1'b1, 1'b0, 2'b10, 12'h030, 32'h0);
        #1;
        chk("t3b_rmw_no_gnt", 32'(b_gnt), 32'h0);
        chk("t3b_rmw_we", 32'(ram_write_en), 32'h1);
        chk("t3b_rmw_waddr", 32'(ram_write_addr), 32'h030);
        chk("t3b_rmw_din", ram_din, 32'hAABBCC55);
        chk("t3b_rmw_no_rvalid", 32'(b_rvalid), 32'h0);
        @(negedge clk); #1;
        chk("t3b_ld_gnt", 32'(b_gnt), 32'h1);
        chk("t3b_ld_we", 32'(ram_write_en), 32'h0);
        @(negedge clk);
        drive_b(1'b1, 1'b1, 2'b01, 12'h030, 32'hFFFF6677);
        #1;
        chk("t3b_ld_rdata", b_rdata, 32'hAABBCC55);
        chk("t3h_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        #1;
        chk("t3h_rmw_din", ram_din, 32'hAABB6677);
        chk("t3h_rmw_we", 32'(ram_write_en), 32'h1);
        @(negedge clk);
        drive_b(1'b1, 1'b0, 2'b10, 12'h030, 32'h0);
        #1;
        chk("t3h_ld_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        #1;
        chk("t3h_ld_rdata", b_rdata, 32'hAABB6677);

        // 4. Contention after a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        a_req  = 1'b1;
        a_addr = 12'h010;
        drive_b(1'b1, 1'b0, 2'b10, 12'h020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("t4_a_gnt%0d", i), 32'(a_gnt), 32'(exp_a[i]));
            chk($sformatf("t4_b_gnt%0d", i), 32'(b_gnt), 32'(exp_b[i]));
            if (i > 0) begin
                chk($sformatf("t4_a_rvalid%0d", i), 32'(a_rvalid), 32'(exp_a[i-1]));
                chk($sformatf("t4_b_rvalid%0d", i), 32'(b_rvalid), 32'(exp_b[i-1]));
            end
        end
        @(negedge clk);
        a_req = 1'b0;
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        #1;
        chk("t4_b_rdata", b_rdata, 32'h11223344);

        // 5. Reset during RMW suppresses the write
        @(negedge clk);
        wr_base = wr_cnt;
        drive_b(1'b1, 1'b1, 2'b00, 12'h020, 32'h00000099);
        #1;
        chk("t5_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 32'(ram_write_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_mem", mem[12'h020 >> 2], 32'h11223344);
        chk("t5_wr_count", 32'(wr_cnt - wr_base), 32'h0);
        chk("t5_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("t5_b_rvalid", 32'(b_rvalid), 32'h0);
        chk("t5_idle_we", 32'(ram_write_en), 32'h0);
        drive_b(1'b1, 1'b0, 2'b10, 12'h020, 32'h0);
        #1;
        chk("t5_idle_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        #1;
        chk("t5_ld_rdata", b_rdata, 32'h11223344);

        // 6. Size 11 behaves as a word store
        @(negedge clk);
        wr_base = wr_cnt;
        drive_b(1'b1, 1'b1, 2'b11, 12'h040, 32'h01020304);
        #1;
        chk("t6_gnt", 32'(b_gnt), 32'h1);
        chk("t6_we", 32'(ram_write_en), 32'h1);
        chk("t6_din", ram_din, 32'h01020304);
        @(negedge clk);
        drive_b(1'b1, 1'b0, 2'b10, 12'h040, 32'h0);
        #1;
        chk("t6_ld_gnt", 32'(b_gnt), 32'h1);
        chk("t6_ld_we", 32'(ram_write_en), 32'h0);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        #1;
        chk("t6_ld_rdata", b_rdata, 32'h01020304);
        chk("t6_wr_count", 32'(wr_cnt - wr_base), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
